pipe_skid_full: RTL and testbench
=================================

Name: pipe_skid_full

Overview:
- Fully registered valid/ready pipeline slice that consumes the valid/data stream of the ready-pipelined middle stage and feeds the next downstream consumer.
- Breaks both the forward (valid/data) and backward (ready) combinational paths using a main register plus a one-entry skid register.
- Sustains one transfer per cycle with no bubbles under continuous flow.

Parameters:
DATA_W, 3, payload width; matches the 3-bit data path of the neighbouring stage.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
valid_in  input  1  upstream data valid
data_in  input  DATA_W  upstream payload
ready_in  output  1  registered ready to upstream
valid_out  output  1  registered valid to downstream
data_out  output  DATA_W  registered payload to downstream
ready_out  input  1  downstream ready
occupancy  output  2  number of held entries: 0, 1 or 2

Behaviour:
- Handshake events:
  - in_fire = valid_in & ready_in.
  - out_fire = valid_out & ready_out.
  - A transfer occurs only on a fire; valid without ready transfers nothing.
- Storage:
  - main_q (DATA_W) drives data_out.
  - skid_q (DATA_W) is the overflow entry.
- State machine (2-bit): EMPTY, BUSY (main holds an entry), FULL (main and skid both hold entries).
  - valid_out = (state != EMPTY).
  - occupancy = 0 / 1 / 2 for EMPTY / BUSY / FULL.
  - ready_in is a flop loaded each cycle with (next_state != FULL). It has no combinational path from ready_out.
- Transitions:
  - EMPTY: in_fire -> BUSY, main_q <= data_in. Otherwise stay.
  - BUSY, in_fire & out_fire -> BUSY, main_q <= data_in.
  - BUSY, in_fire & !out_fire -> FULL, skid_q <= data_in; main_q unchanged.
  - BUSY, !in_fire & out_fire -> EMPTY.
  - BUSY, neither fire -> stay.
  - FULL: in_fire cannot occur because ready_in = 0. out_fire -> BUSY, main_q <= skid_q. Otherwise stay.
- Latency and throughput:
  - Latency is 1 cycle: a word accepted at edge N appears on data_out after edge N, provided the slice was EMPTY or BUSY with a simultaneous drain.
  - Throughput is one word per cycle while ready_out stays high.
- Ordering and stability:
  - Strict FIFO order; no word is duplicated or dropped.
  - While valid_out = 1 and ready_out = 0, data_out and valid_out must hold stable.
- Backpressure:
  - ready_out low for one cycle while BUSY with upstream streaming puts the slice in FULL. ready_in drops the following cycle; the skid entry absorbs the word already in flight.
- Reset (async assert, sync release by the system):
  - state = EMPTY.
  - valid_out = 0, ready_in = 0, occupancy = 0.
  - main_q = 0, skid_q = 0.
  - ready_in goes high on the first rising edge after sys_rst_n deasserts.
- Reset mid-operation: all held entries are discarded with no output glitch beyond the forced-low valid_out.
- Width: payload is passed through untouched; no arithmetic.

Decomposition:
- Shared package holds:
  - state encodings: EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2. 2'd3 is illegal and recovers to EMPTY.
  - the default DATA_W constant, shared with the neighbouring pipe stages.
- No sub-module is needed. Control FSM and the two data registers stay in one module.

Test Plan:
- Reset release, valid_in = 1, data_in = 3'd5, ready_out = 1 -> ready_in = 1 one edge after release; data_out = 5 with valid_out = 1 one cycle after acceptance; occupancy = 1.
- Continuous stream 1, 2, 3, 4, 5, 6, 7 with ready_out held 1 -> output sequence 1..7 on consecutive cycles; ready_in never drops; occupancy stays 1.
- Stream 1, 2, 3 with ready_out = 0 from the first output cycle -> occupancy = 2, ready_in = 0, data_out holds 1. Then ready_out = 1 -> outputs 1, 2, 3 in order with no loss.
- Random valid_in and ready_out toggling for 1000 cycles with a scoreboard -> in-order, loss-free, duplicate-free; data_out stable whenever valid_out & !ready_out; ready_in never high when occupancy = 2.
- sys_rst_n pulsed low while FULL (entries 6, 7) -> valid_out, ready_in and occupancy go to 0 immediately. After release, words 6 and 7 never appear; new word 3'd2 passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_skid_full_pkg.sv
// Shared definitions for the registered valid/ready pipe slices:
// skid FSM encodings and the common payload width.
package pipe_skid_full_pkg;

    localparam int PIPE_DATA_W = 3;

    // 2'd3 is never entered; the FSM recovers it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] state_occupancy(input skid_state_e st);
        case (st)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_full.sv
// Fully registered pipe slice: main register drives the output, a one-entry
// skid register catches the word in flight when the downstream stalls.
module pipe_skid_full
    import pipe_skid_full_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_out,
    output logic [1:0]        occupancy
);

    skid_state_e       state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign valid_out = (state != EMPTY);
    assign data_out  = main_q;
    assign occupancy = state_occupancy(state);
    assign in_fire   = valid_in & ready_in;
    assign out_fire  = valid_out & ready_out;

    // ready_in is loaded with (next state != FULL) in every branch, so the
    // upstream never sees a combinational path from ready_out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            ready_in <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_in <= 1'b1;
                    if (in_fire) begin
                        state  <= BUSY;
                        main_q <= data_in;
                    end
                end
                BUSY: begin
                    ready_in <= 1'b1;
                    if (in_fire && out_fire) begin
                        main_q <= data_in;
                    end else if (in_fire) begin
                        state    <= FULL;
                        skid_q   <= data_in;
                        ready_in <= 1'b0;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state    <= BUSY;
                        main_q   <= skid_q;
                        ready_in <= 1'b1;
                    end else begin
                        ready_in <= 1'b0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    ready_in <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_full.sv
// Directed + random bench for pipe_skid_full against a queue-based model
// of a two-entry registered slice.
module tb_pipe_skid_full;

    localparam int DATA_W = 3;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              ready_out;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mq[$];
    bit                ready_m;

    pipe_skid_full #(.DATA_W(DATA_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out),
        .occupancy (occupancy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid_out", {31'd0, valid_out}, {31'd0, mq.size() != 0});
        chk("ready_in", {31'd0, ready_in}, {31'd0, ready_m});
        chk("occupancy", {30'd0, occupancy}, mq.size());
        if (mq.size() != 0)
            chk("data_out", {29'd0, data_out}, {29'd0, mq[0]});
    endtask

    // One clock: a word enters on valid&ready, leaves the head on
    // valid_out&ready_out; the slice holds at most two words and advertises
    // ready whenever it holds fewer than two.
    task automatic tick(output bit accepted);
        bit                inf, outf, hold;
        logic [DATA_W-1:0] held;
        inf  = valid_in & ready_m;
        outf = (mq.size() != 0) & ready_out;
        hold = (mq.size() != 0) && !ready_out;
        held = data_out;
        @(posedge sys_clk);
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(data_in);
        ready_m = (mq.size() < 2);
        #1;
        check_model();
        if (hold) chk("stable", {29'd0, data_out}, {29'd0, held});
        accepted = inf;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        bit acc;
        int budget;
        valid_in = 1'b1;
        data_in  = w;
        acc      = 1'b0;
        budget   = 0;
        while (!acc && budget < 50) begin
            tick(acc);
            budget++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    initial begin
        bit acc;
        sys_rst_n = 1'b0;
        valid_in  = 1'b1;
        data_in   = 3'd5;
        ready_out = 1'b1;
        ready_m   = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_data_out", {29'd0, data_out}, 32'd0);

        // Release away from the edge; first edge raises ready_in only.
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick(acc);
        chk("ready_after_release", {31'd0, ready_in}, 32'd1);
        tick(acc);
        chk("first_word", {29'd0, data_out}, 32'd5);
        chk("first_valid", {31'd0, valid_out}, 32'd1);
        chk("first_occ", {30'd0, occupancy}, 32'd1);
        valid_in = 1'b0;
        idle(2);

        // Continuous stream at full rate.
        for (int w = 1; w <= 7; w++) begin
            valid_in = 1'b1;
            data_in  = 3'(w);
            tick(acc);
            chk("stream_accept", {31'd0, acc}, 32'd1);
            chk("stream_out", {29'd0, data_out}, 32'(w));
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        valid_in = 1'b0;
        idle(2);

        // Backpressure from the first output cycle.
        ready_out = 1'b0;
        send(3'd1);
        send(3'd2);
        chk("bp_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_ready_in", {31'd0, ready_in}, 32'd0);
        chk("bp_head", {29'd0, data_out}, 32'd1);
        valid_in = 1'b1;
        data_in  = 3'd3;
        idle(3);
        ready_out = 1'b1;
        send(3'd3);
        idle(4);
        chk("bp_drained", {30'd0, occupancy}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            valid_in  = 1'($urandom_range(0, 1));
            data_in   = 3'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        idle(3);

        // Reset while FULL with 6 and 7.
        ready_out = 1'b0;
        send(3'd6);
        send(3'd7);
        chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("midrst_ready_in", {31'd0, ready_in}, 32'd0);
        chk("midrst_occ", {30'd0, occupancy}, 32'd0);
        mq.delete();
        ready_m = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ready_out = 1'b1;
        tick(acc);
        send(3'd2);
        chk("post_rst_word", {29'd0, data_out}, 32'd2);
        chk("post_rst_valid", {31'd0, valid_out}, 32'd1);
        idle(3);
        chk("post_rst_empty", {31'd0, valid_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
